// File: rtl/shim_shutdown_fault_monitor_pkg.sv
// shim_shutdown_pkg
//   Shared constants for the shutdown fault monitor: FSM state encoding
//   (also exported on monitor_state), channel/select/timestamp widths and a
//   saturating increment helper for the optional ARMED-to-fault timestamp.
//   The timestamp feature is enabled by defining SHUTDOWN_TIMESTAMP_EN.
package shim_shutdown_pkg;

    localparam int SHUTDOWN_N_CH  = 8;
    localparam int SHUTDOWN_SEL_W = 3;
    localparam int SHUTDOWN_TS_W  = 32;

    typedef logic [1:0] monitor_state_t;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMING = 2'd1;
    localparam logic [1:0] ARMED  = 2'd2;
    localparam logic [1:0] FAULT  = 2'd3;

    function automatic logic [SHUTDOWN_TS_W-1:0] ts_sat_inc(input logic [SHUTDOWN_TS_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/shim_shutdown_fault_monitor_if.sv
// shim_shutdown_fault_monitor_if
//   Bundles the scanner-facing and firmware-facing signals of the shutdown
//   fault monitor.
//   slave  : the monitor (consumes controls and sense, drives status)
//   master : the environment (firmware registers + sense scanner)
//   Signals:
//     monitor_en        arm/disarm level
//     fault_mask        per-channel ignore mask
//     fault_ack         one-cycle acknowledge of a latched fault
//     shutdown_sense    sticky per-channel bits from the scanner
//     shutdown_sense_en enable back to the scanner
//     shutdown_req      latched shutdown request
//     fault_irq         one-cycle interrupt on fault entry
//     first_fault_ch    lowest unmasked channel at fault entry
//     fault_vector      accumulated unmasked faulting channels
//     monitor_state     current FSM state
//     fault_timestamp   ARMED-to-fault cycle count (0 unless SHUTDOWN_TIMESTAMP_EN)
interface shim_shutdown_fault_monitor_if;
    import shim_shutdown_pkg::*;

    logic                      monitor_en;
    logic [SHUTDOWN_N_CH-1:0]  fault_mask;
    logic                      fault_ack;
    logic [SHUTDOWN_N_CH-1:0]  shutdown_sense;
    logic                      shutdown_sense_en;
    logic                      shutdown_req;
    logic                      fault_irq;
    logic [SHUTDOWN_SEL_W-1:0] first_fault_ch;
    logic [SHUTDOWN_N_CH-1:0]  fault_vector;
    monitor_state_t            monitor_state;
    logic [SHUTDOWN_TS_W-1:0]  fault_timestamp;

    modport slave (
        input  monitor_en,
        input  fault_mask,
        input  fault_ack,
        input  shutdown_sense,
        output shutdown_sense_en,
        output shutdown_req,
        output fault_irq,
        output first_fault_ch,
        output fault_vector,
        output monitor_state,
        output fault_timestamp
    );

    modport master (
        output monitor_en,
        output fault_mask,
        output fault_ack,
        output shutdown_sense,
        input  shutdown_sense_en,
        input  shutdown_req,
        input  fault_irq,
        input  first_fault_ch,
        input  fault_vector,
        input  monitor_state,
        input  fault_timestamp
    );

endinterface

// File: rtl/shim_shutdown_fault_monitor_enc.sv
// shim_priority_enc8
//   Combinational lowest-set-index encoder for the 8 shutdown channels.
//   Ports:
//     vec   in  8  channel bits
//     idx   out 3  index of the lowest set bit (0 when none set)
//     valid out 1  any bit set
module shim_priority_enc8
    import shim_shutdown_pkg::*;
(
    input  logic [SHUTDOWN_N_CH-1:0]  vec,
    output logic [SHUTDOWN_SEL_W-1:0] idx,
    output logic                      valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Walk downward so the lowest set bit is the last one written.
        for (int i = SHUTDOWN_N_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = SHUTDOWN_SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/shim_shutdown_fault_monitor.sv
// shim_shutdown_fault_monitor
//   Owns the shutdown sense scanner enable and watches its sticky sense
//   vector. Any unmasked channel while ARMED latches a shutdown request,
//   fires a one-cycle interrupt, and records the first faulting channel plus
//   an accumulated fault vector until firmware acknowledges.
//   Optional feature macro: SHUTDOWN_TIMESTAMP_EN (ARMED-to-fault cycle count
//   on fault_timestamp; tied to zero when undefined).
//   Ports:
//     clk  in  system clock, posedge
//     rst  in  asynchronous active-high reset
//     bus  slave modport of shim_shutdown_fault_monitor_if
//   Parameters:
//     ARM_DELAY  cycles sense_en is held low after arming (min 1)
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | disarmed, scanner disabled
//   ARMING | scanner held disabled for ARM_DELAY cycles to clear stickies
//   ARMED  | scanner enabled, watching unmasked channels
//   FAULT  | shutdown requested, accumulating hits until fault_ack
module shim_shutdown_fault_monitor
    import shim_shutdown_pkg::*;
#(
    parameter int unsigned ARM_DELAY = 16
)(
    input  logic                             clk,
    input  logic                             rst,
    shim_shutdown_fault_monitor_if.slave     bus
);

    localparam int ARM_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
    localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_DELAY - 1);

    monitor_state_t            state;
    monitor_state_t            state_nxt;
    logic [ARM_W-1:0]          arm_cnt;
    logic [SHUTDOWN_N_CH-1:0]  hit;
    logic [SHUTDOWN_SEL_W-1:0] hit_idx;
    logic                      hit_valid;
    logic                      arm_start;
    logic                      fault_entry;

    logic                      sense_en_q;
    logic                      req_q;
    logic                      irq_q;
    logic [SHUTDOWN_SEL_W-1:0] first_q;
    logic [SHUTDOWN_N_CH-1:0]  vector_q;

    // Mask is applied combinationally so a mask change takes effect on the
    // very next decision; it never reaches back into the latched vector.
    assign hit = bus.shutdown_sense & ~bus.fault_mask;

    shim_priority_enc8 u_enc (
        .vec   (hit),
        .idx   (hit_idx),
        .valid (hit_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.monitor_en) begin
                    state_nxt = ARMING;
                end
            end
            ARMING: begin
                if (!bus.monitor_en) begin
                    state_nxt = IDLE;
                end else if (arm_cnt == '0) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                // Disarm wins over a simultaneous hit.
                if (!bus.monitor_en) begin
                    state_nxt = IDLE;
                end else if (hit_valid) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                if (bus.fault_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign arm_start   = (state == IDLE)  && (state_nxt == ARMING);
    assign fault_entry = (state == ARMED) && (state_nxt == FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            arm_cnt    <= '0;
            sense_en_q <= 1'b0;
            req_q      <= 1'b0;
            irq_q      <= 1'b0;
            first_q    <= '0;
            vector_q   <= '0;
        end else begin
            state <= state_nxt;

            if (arm_start) begin
                arm_cnt <= ARM_LOAD;
            end else if ((state == ARMING) && (arm_cnt != '0)) begin
                arm_cnt <= arm_cnt - 1'b1;
            end

            // Outputs are registered from the next state so they line up
            // with monitor_state in the same cycle.
            sense_en_q <= (state_nxt == ARMED) || (state_nxt == FAULT);
            req_q      <= (state_nxt == FAULT);
            irq_q      <= fault_entry;

            if (arm_start) begin
                vector_q <= '0;
                first_q  <= '0;
            end else if (fault_entry) begin
                vector_q <= hit;
                first_q  <= hit_idx;
            end else if (state == FAULT) begin
                // Keeps accumulating through the ack cycle itself.
                vector_q <= vector_q | hit;
            end
        end
    end

`ifdef SHUTDOWN_TIMESTAMP_EN
    logic [SHUTDOWN_TS_W-1:0] ts_cnt;
    logic [SHUTDOWN_TS_W-1:0] ts_q;

    // ts_cnt holds (ARMED cycles so far - 1); capturing ts_cnt+1 on the
    // transition gives the number of cycles spent in ARMED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            if ((state != ARMED) && (state_nxt == ARMED)) begin
                ts_cnt <= '0;
            end else if (state == ARMED) begin
                ts_cnt <= ts_sat_inc(ts_cnt);
            end

            if (arm_start) begin
                ts_q <= '0;
            end else if (fault_entry) begin
                ts_q <= ts_sat_inc(ts_cnt);
            end
        end
    end

    assign bus.fault_timestamp = ts_q;
`else
    assign bus.fault_timestamp = '0;
`endif

    assign bus.shutdown_sense_en = sense_en_q;
    assign bus.shutdown_req      = req_q;
    assign bus.fault_irq         = irq_q;
    assign bus.first_fault_ch    = first_q;
    assign bus.fault_vector      = vector_q;
    assign bus.monitor_state     = state;

endmodule
